// File: rtl/arm_control_unit.sv
// Single-cycle ARM control unit: decodes instr[31:12] into DataPath strobes,
// holds the NZCV flags register and gates state-changing strobes on the condition field.
module arm_control_unit #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [1:0]  alu_ctl,
    output logic [3:0]  flags,
    output logic        undef
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;

    assign cond  = instr[31:28];
    assign op    = instr[27:26];
    assign funct = instr[25:20];
    assign rd    = instr[15:12];
    assign cmd   = funct[4:1];

    logic [3:0] flags_q, flags_d;

    logic       dec_reg_write, dec_mem_write, dec_branch, dec_undef;
    logic       dec_mem_to_reg, dec_alu_src;
    logic [1:0] dec_imm_src, dec_reg_src, dec_alu_ctl;
    logic       flag_w_nz, flag_w_cv;
    logic       cond_ex;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_undef      = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_imm_src    = 2'b00;
        dec_reg_src    = 2'b00;
        dec_alu_ctl    = 2'b00;
        flag_w_nz      = 1'b0;
        flag_w_cv      = 1'b0;
        unique case (op)
            2'b00: begin
                dec_alu_src   = funct[5];
                dec_reg_write = 1'b1;
                flag_w_nz     = funct[0];
                case (cmd)
                    4'b0100: begin
                        dec_alu_ctl = 2'b00;
                        flag_w_cv   = funct[0];
                    end
                    4'b0010: begin
                        dec_alu_ctl = 2'b01;
                        flag_w_cv   = funct[0];
                    end
                    4'b0000: dec_alu_ctl = 2'b10;
                    4'b1100: dec_alu_ctl = 2'b11;
                    4'b1010: begin
                        // CMP only exists in its flag-setting form
                        dec_alu_ctl   = 2'b01;
                        dec_reg_write = 1'b0;
                        flag_w_cv     = funct[0];
                        dec_undef     = ~funct[0];
                    end
                    default: dec_undef = 1'b1;
                endcase
            end
            2'b01: begin
                dec_alu_src = 1'b1;
                dec_imm_src = 2'b01;
                dec_alu_ctl = funct[3] ? 2'b00 : 2'b01;
                dec_undef   = funct[5];
                if (funct[0]) begin
                    dec_reg_write  = 1'b1;
                    dec_mem_to_reg = 1'b1;
                end else begin
                    dec_mem_write = 1'b1;
                    dec_reg_src   = 2'b10;
                end
            end
            2'b10: begin
                dec_imm_src = 2'b10;
                dec_alu_src = 1'b1;
                dec_alu_ctl = 2'b00;
                dec_reg_src = 2'b01;
                dec_branch  = 1'b1;
            end
            default: dec_undef = 1'b1;
        endcase
    end

    logic n, z, c, v;
    assign {n, z, c, v} = flags_q;

    always_comb begin
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    logic exec;
    assign exec = cond_ex & ~dec_undef;

    assign undef      = dec_undef;
    assign reg_write  = dec_reg_write & exec;
    assign mem_write  = dec_mem_write & exec;
    assign pc_src     = (dec_branch | (dec_reg_write & (rd == 4'd15))) & exec;
    assign mem_to_reg = dec_mem_to_reg & ~dec_undef;
    assign alu_src    = dec_alu_src & ~dec_undef;
    assign imm_src    = dec_undef ? 2'b00 : dec_imm_src;
    assign reg_src    = dec_undef ? 2'b00 : dec_reg_src;
    assign alu_ctl    = dec_undef ? 2'b00 : dec_alu_ctl;

    always_comb begin
        flags_d = flags_q;
        if (exec && flag_w_nz) flags_d[3:2] = alu_flags[3:2];
        if (exec && flag_w_cv) flags_d[1:0] = alu_flags[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= FLAGS_RESET;
        else       flags_q <= flags_d;
    end

    assign flags = flags_q;

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed bench for arm_control_unit: expected strobes/flags are queued per step
// and popped at the falling edge when the DUT outputs are sampled.
module tb_arm_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        pc_src, reg_write, mem_write, mem_to_reg, alu_src, undef;
    logic [1:0]  imm_src, reg_src, alu_ctl;
    logic [3:0]  flags;

    arm_control_unit #(.FLAGS_RESET(4'b0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .alu_flags  (alu_flags),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .imm_src    (imm_src),
        .reg_src    (reg_src),
        .alu_ctl    (alu_ctl),
        .flags      (flags),
        .undef      (undef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [11:0] ctl;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // {pc_src, reg_write, mem_write, mem_to_reg, alu_src, imm_src, reg_src, alu_ctl, undef}
    function automatic logic [11:0] ctl(input logic pc, input logic rw, input logic mw,
                                        input logic m2r, input logic as,
                                        input logic [1:0] imm, input logic [1:0] rs,
                                        input logic [1:0] alu, input logic ud);
        return {pc, rw, mw, m2r, as, imm, rs, alu, ud};
    endfunction

    task automatic check_out();
        exp_t        e;
        logic [11:0] obs;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed 0 entries expected 1");
        end
        if (sb_q.size() != 0) begin
            e   = sb_q.pop_front();
            obs = {pc_src, reg_write, mem_write, mem_to_reg, alu_src,
                   imm_src, reg_src, alu_ctl, undef};
            checks++;
            assert (obs === e.ctl) else begin
                errors++;
                $error("FAIL %s ctl observed %b expected %b", e.tag, obs, e.ctl);
            end
            checks++;
            assert (flags === e.flg) else begin
                errors++;
                $error("FAIL %s flags observed %b expected %b", e.tag, flags, e.flg);
            end
        end
    endtask

    // flg is the flags value expected before this step's clock edge
    task automatic step(input string tag, input logic [31:0] i, input logic [3:0] af,
                        input logic rst, input logic [11:0] ectl, input logic [3:0] eflg);
        exp_t e;
        instr     = i;
        alu_flags = af;
        reset     = rst;
        e.tag     = tag;
        e.ctl     = ectl;
        e.flg     = eflg;
        sb_q.push_back(e);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        instr     = 32'h0;
        alu_flags = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        step("subs_set1111", 32'hE0510002, 4'b1111, 1'b0,
             ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0), 4'b0000);
        step("reset_prio",   32'hE0510002, 4'b1010, 1'b1,
             ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0), 4'b1111);
        step("beq_after_rst", 32'h0A000002, 4'b0000, 1'b0,
             ctl(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b00, 0), 4'b0000);
        step("subs_z",       32'hE0510002, 4'b0100, 1'b0,
             ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0), 4'b0000);
        step("beq_taken",    32'h0A000002, 4'b0000, 1'b0,
             ctl(1, 0, 0, 0, 1, 2'b10, 2'b01, 2'b00, 0), 4'b0100);
        step("bne_not",      32'h1A000002, 4'b0000, 1'b0,
             ctl(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b00, 0), 4'b0100);
        step("add_nos",      32'hE0810002, 4'b1111, 1'b0,
             ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0), 4'b0100);
        step("cmp",          32'hE1510002, 4'b0011, 1'b0,
             ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0), 4'b0100);
        step("str",          32'hE58B1000, 4'b1111, 1'b0,
             ctl(0, 0, 1, 0, 1, 2'b01, 2'b10, 2'b00, 0), 4'b0011);
        step("ldr_u0",       32'hE51B1004, 4'b1111, 1'b0,
             ctl(0, 1, 0, 1, 1, 2'b01, 2'b00, 2'b01, 0), 4'b0011);
        step("ldr_pc",       32'hE59BF000, 4'b1111, 1'b0,
             ctl(1, 1, 0, 1, 1, 2'b01, 2'b00, 2'b00, 0), 4'b0011);
        step("orr",          32'hE1810002, 4'b0000, 1'b0,
             ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0), 4'b0011);
        step("and",          32'hE0010002, 4'b0000, 1'b0,
             ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0), 4'b0011);
        step("add_to_pc",    32'hE081F002, 4'b0000, 1'b0,
             ctl(1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0), 4'b0011);
        step("subs_z_again", 32'hE0510002, 4'b0100, 1'b0,
             ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0), 4'b0011);
        step("ldrne_pc",     32'h159BF000, 4'b1111, 1'b0,
             ctl(0, 0, 0, 1, 1, 2'b01, 2'b00, 2'b00, 0), 4'b0100);
        step("undef_op11",   32'hEC000000, 4'b1111, 1'b0,
             ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1), 4'b0100);
        step("subs_nv",      32'hF0510002, 4'b1111, 1'b0,
             ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0), 4'b0100);
        step("undef_cmp_nos", 32'hE1410002, 4'b1111, 1'b0,
             ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1), 4'b0100);
        step("undef_mem_reg", 32'hE79B1000, 4'b1111, 1'b0,
             ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1), 4'b0100);
        step("flags_held",   32'hE0810002, 4'b0000, 1'b0,
             ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0), 4'b0100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_control_unit.md
Name: arm_control_unit

Overview:
- Single-cycle ARM control unit, directly upstream of DataPath.
- Decodes instr[31:12] into the DataPath control strobes: pc_src, reg_write, mem_write, mem_to_reg, alu_src, imm_src, reg_src, alu_ctl.
- Holds the architectural NZCV flags register and evaluates the condition field.
- Gates every state-changing strobe with the condition result. Flags are captured from DataPath's ALU flag output at the clock edge.

Parameters:
FLAGS_RESET  4'b0000  NZCV value loaded on reset, ordered {N,Z,C,V}

Ports:
clk         in   1   system clock, all state on rising edge
reset       in   1   synchronous, active-high; clears flags to FLAGS_RESET
instr       in   32  current instruction; only [31:12] used
alu_flags   in   4   {N,Z,C,V} from DataPath ALU for the current instruction
pc_src      out  1   1 = PC loads result (branch or write to r15)
reg_write   out  1   register file write enable
mem_write   out  1   data memory write enable
mem_to_reg  out  1   1 = writeback selects memory read data
alu_src     out  1   1 = ALU B operand is extended immediate
imm_src     out  2   00 imm8 (data-processing), 01 imm12 (memory), 10 imm24<<2 sign-extended (branch)
reg_src     out  2   [0]=1 read port 1 is r15; [1]=1 read port 2 is Rd (STR)
alu_ctl     out  2   00 ADD, 01 SUB, 10 AND, 11 ORR
flags       out  4   current NZCV register contents
undef       out  1   1 = instruction not decodable; all writes suppressed

Behaviour:
- Clocking and reset
  - Interface: one clock; reset is synchronous and active-high (ports clk and reset).
  - Outputs other than flags are combinational from instr and flags.
  - Only state is the flags register; flags reads FLAGS_RESET the cycle after reset is sampled high.
  - Reset has priority over a same-edge flag update.
- Decode fields: cond=instr[31:28], op=instr[27:26], funct=instr[25:20], Rd=instr[15:12]; I=funct[5], cmd=funct[4:1], S=funct[0].
- op=00, data-processing
  - alu_src=I, imm_src=00, reg_src=00, mem_to_reg=0.
  - cmd mapping: 0100 ADD→00, 0010 SUB→01, 0000 AND→10, 1100 ORR→11, 1010 CMP→01.
  - Decoded reg_write=1 except CMP (0).
  - CMP with S=0 is undefined.
- op=01, memory
  - alu_src=1, imm_src=01.
  - alu_ctl=00 when U=funct[3]=1; alu_ctl=01 (SUB) when U=0.
  - funct[0]=1 LDR: reg_write=1, mem_to_reg=1, reg_src=00.
  - funct[0]=0 STR: mem_write=1, reg_src=10.
  - I=1 (register offset) is undefined.
- op=10, branch
  - imm_src=10, alu_src=1, alu_ctl=00, reg_src=01.
  - Decoded branch=1, reg_write=0.
- op=11, or any unlisted cmd: undefined.
- Flag write enables
  - flag_w_nz = S on data-processing.
  - flag_w_cv = S & (ADD|SUB|CMP).
  - Both are 0 for memory and branch.
- Condition evaluation (cond_ex), from the registered flags:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1.
  - cond=1111 gives cond_ex=0.
- Gating
  - reg_write = dec_reg_write & cond_ex & ~undef.
  - mem_write = dec_mem_write & cond_ex & ~undef.
  - pc_src = (branch | (dec_reg_write & Rd==15)) & cond_ex & ~undef.
  - At the clock edge, when cond_ex & ~undef: N,Z update from alu_flags if flag_w_nz; C,V update if flag_w_cv. Otherwise flags hold.
  - Non-gated steering outputs (alu_src, imm_src, reg_src, alu_ctl, mem_to_reg) follow decode regardless of cond_ex; for undef they are all 0.
- Undefined instruction: undef=1, no strobes, flags hold.
- Flag timing: updated flags are visible to the instruction presented on the following cycle, never the same one (no combinational path from alu_flags to any strobe).

Test Plan:
- Reset with FLAGS_RESET=0: pulse reset for 1 cycle after flags were 1111 → flags=0000 next cycle; instr 0x0A000002 (BEQ) → pc_src=0.
- SUBS r0,r1,r2 (0xE0510002), alu_flags=0100 → same cycle reg_write=1, alu_ctl=01, alu_src=0; after edge flags=0100. Then BEQ 0x0A000002 → pc_src=1, imm_src=10, reg_src=01. Then BNE 0x1A000002 → pc_src=0.
- ADD r0,r1,r2 without S (0xE0810002), alu_flags=1111 → flags unchanged across edge; CMP r1,r2 (0xE1510002), alu_flags=0011 → reg_write=0, flags=0011.
- STR r1,[r11] (0xE58B1000) → mem_write=1, reg_write=0, alu_src=1, imm_src=01, reg_src=10, alu_ctl=00; LDR with U=0 (0xE51B1004) → alu_ctl=01, mem_to_reg=1, reg_write=1.
- LDR pc,[r11] (0xE59BF000) → pc_src=1, reg_write=1; same with cond NE while Z=1 (0x159BF000) → pc_src=0, reg_write=0.
- Undefined (0xEC000000, op=11) and SUBS with cond=1111 → undef=1 or cond_ex=0 respectively: all strobes 0, flags hold with alu_flags=1111 driven.
